// File: rtl/difftest_pkg.sv
// Shared definitions for the difftest commit path.
// Contents:
//   TRAP_OPCODE  - inst[6:0] value that marks the simulation trap instruction
//   DT_XLEN      - reference data/PC width of the packed commit record
//   WDEST_OUT_W  - width of the destination index on the difftest side
//   commit_rec_t - one retired-instruction record {pc, inst, wen, wdest, wdata}
//   REC_W        - bit width of commit_rec_t
//   is_trap()    - opcode match helper
package difftest_pkg;

  localparam logic [6:0] TRAP_OPCODE = 7'h6b;
  localparam int unsigned DT_XLEN = 64;
  localparam int unsigned WDEST_OUT_W = 8;

  typedef struct packed {
    logic [DT_XLEN-1:0] pc;
    logic [31:0]        inst;
    logic               wen;
    logic [4:0]         wdest;
    logic [DT_XLEN-1:0] wdata;
  } commit_rec_t;

  localparam int unsigned REC_W = $bits(commit_rec_t);

  function automatic logic is_trap(input logic [31:0] inst, input logic [6:0] opcode);
    return (inst[6:0] == opcode);
  endfunction

endpackage

// File: rtl/commit_ring_mport.sv
// DEPTH-entry ring buffer with NCOMMIT write and NCOMMIT read ports.
// Writes fill consecutive slots starting at tail; reads present the
// NCOMMIT oldest slots starting at head combinationally. Pointers wrap
// modulo DEPTH, so a multi-slot access across index DEPTH-1 is seamless.
// Ports:
//   clock, reset - clock and asynchronous active-high reset
//   wr_cnt       - number of lanes of wr_data to append this cycle
//   wr_data      - NCOMMIT packed records, lane 0 oldest
//   rd_cnt       - number of oldest entries to retire this cycle
//   rd_data      - NCOMMIT packed records starting at head
//   count        - current number of stored entries
module commit_ring_mport #(
  parameter int unsigned NCOMMIT = 2,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned W       = 166
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [$clog2(NCOMMIT):0]   wr_cnt,
  input  logic [NCOMMIT*W-1:0]       wr_data,
  input  logic [$clog2(NCOMMIT):0]   rd_cnt,
  output logic [NCOMMIT*W-1:0]       rd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;
  localparam int unsigned CW = $clog2(NCOMMIT) + 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] head_r;
  logic [AW-1:0] tail_r;
  logic [OW-1:0] count_r;

  // Storage write: lanes below wr_cnt land in consecutive slots from tail.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NCOMMIT; i++) begin
      if (CW'(i) < wr_cnt) begin
        mem_r[tail_r + AW'(i)] <= wr_data[i*W +: W];
      end
    end
  end

  // Pointer and occupancy update; push and pop may happen on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      head_r  <= head_r + AW'(rd_cnt);
      tail_r  <= tail_r + AW'(wr_cnt);
      count_r <= count_r + OW'(wr_cnt) - OW'(rd_cnt);
    end
  end

  // Read ports: the NCOMMIT oldest slots, wrapping past DEPTH-1.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NCOMMIT; i++) begin
      rd_data[i*W +: W] = mem_r[head_r + AW'(i)];
    end
  end

  assign count = count_r;

endmodule

// File: rtl/difftest_commit_queue_sva.sv
// Protocol checker for the retire-side interface of difftest_commit_queue.
// Flags a retire group whose valid lanes are not a contiguous prefix from
// lane 0 while the queue is accepting; such lanes are dropped by the queue.
// Reported as a warning so simulation continues and the drop can be observed.
// Ports:
//   clock, reset - clock and asynchronous active-high reset
//   in_ready     - queue accepts a group this cycle
//   in_valid     - per-lane retire valid
module difftest_commit_queue_sva #(
  parameter int unsigned NCOMMIT = 2
) (
  input logic               clock,
  input logic               reset,
  input logic               in_ready,
  input logic [NCOMMIT-1:0] in_valid
);

  logic [NCOMMIT-1:0] valid_inc;
  logic               hole;

  // A prefix mask has no bit in common with itself plus one.
  always_comb begin
    valid_inc = in_valid + NCOMMIT'(1);
    hole      = |(in_valid & valid_inc);
  end

  a_valid_prefix: assert property (@(posedge clock) disable iff (reset) !(in_ready && hole))
    else $warning("in_valid has a valid lane above an idle lane; lanes beyond the gap dropped");

endmodule

// File: rtl/difftest_commit_queue.sv
// Multi-lane commit buffer and trap monitor between retire and difftest.
// Up to NCOMMIT records per cycle are buffered in program order and drained
// up to NCOMMIT per cycle onto registered cmt_* outputs. The first drained
// trap instruction ends the stream: lanes after it are masked and kept,
// trap code/PC are latched and all further pushes, drains and counting stop.
// Ports:
//   clock, reset           - clock and asynchronous active-high reset
//   in_valid/in_pc/in_inst/in_wen/in_wdest/in_wdata - retire group, lane 0 oldest
//   in_ready               - a full group fits this cycle (combinational)
//   out_en                 - difftest side permits a drain this cycle
//   a0_value               - architectural x10, source of the trap code
//   cmt_valid/cmt_pc/cmt_inst/cmt_wen/cmt_wdest/cmt_wdata - registered commit lanes
//   trap/trap_code/trap_pc - sticky trap status
//   cycle_cnt/instr_cnt    - cycle and emitted-record counters, frozen at trap
//   occupancy              - current queue entry count
module difftest_commit_queue
  import difftest_pkg::*;
#(
  parameter int unsigned NCOMMIT     = 2,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned XLEN        = 64,
  parameter logic [6:0]  TRAP_OPCODE = difftest_pkg::TRAP_OPCODE
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NCOMMIT-1:0]             in_valid,
  input  logic [NCOMMIT*XLEN-1:0]        in_pc,
  input  logic [NCOMMIT*32-1:0]          in_inst,
  input  logic [NCOMMIT-1:0]             in_wen,
  input  logic [NCOMMIT*5-1:0]           in_wdest,
  input  logic [NCOMMIT*XLEN-1:0]        in_wdata,
  output logic                           in_ready,
  input  logic                           out_en,
  input  logic [XLEN-1:0]                a0_value,
  output logic [NCOMMIT-1:0]             cmt_valid,
  output logic [NCOMMIT*XLEN-1:0]        cmt_pc,
  output logic [NCOMMIT*32-1:0]          cmt_inst,
  output logic [NCOMMIT-1:0]             cmt_wen,
  output logic [NCOMMIT*WDEST_OUT_W-1:0] cmt_wdest,
  output logic [NCOMMIT*XLEN-1:0]        cmt_wdata,
  output logic                           trap,
  output logic [7:0]                     trap_code,
  output logic [XLEN-1:0]                trap_pc,
  output logic [63:0]                    cycle_cnt,
  output logic [63:0]                    instr_cnt,
  output logic [$clog2(DEPTH):0]         occupancy
);

  localparam int unsigned OW = $clog2(DEPTH) + 1;
  localparam int unsigned CW = $clog2(NCOMMIT) + 1;
  // Flat record layout {pc, inst, wen, wdest, wdata}, wdata at bit 0.
  localparam int unsigned RW        = 2*XLEN + 38;
  localparam int unsigned WDEST_LSB = XLEN;
  localparam int unsigned WEN_BIT   = XLEN + 5;
  localparam int unsigned INST_LSB  = XLEN + 6;
  localparam int unsigned PC_LSB    = XLEN + 38;

  logic [OW-1:0]           count_s;
  logic [CW-1:0]           push_cnt_s;
  logic [CW-1:0]           pop_cnt_s;
  logic [CW-1:0]           avail_s;
  logic                    run_s;
  logic                    trap_hit_s;
  logic [XLEN-1:0]         trap_pc_s;
  logic [NCOMMIT*RW-1:0]   wr_data_s;
  logic [NCOMMIT*RW-1:0]   rd_data_s;
  logic                    a0_unused_s;

  assign a0_unused_s = ^a0_value[XLEN-1:8];

  commit_ring_mport #(
    .NCOMMIT (NCOMMIT),
    .DEPTH   (DEPTH),
    .W       (RW)
  ) u_ring (
    .clock   (clock),
    .reset   (reset),
    .wr_cnt  (push_cnt_s),
    .wr_data (wr_data_s),
    .rd_cnt  (pop_cnt_s),
    .rd_data (rd_data_s),
    .count   (count_s)
  );

  difftest_commit_queue_sva #(
    .NCOMMIT (NCOMMIT)
  ) u_sva (
    .clock    (clock),
    .reset    (reset),
    .in_ready (in_ready),
    .in_valid (in_valid)
  );

  // Accept only when a whole group fits in the pre-drain free space.
  always_comb begin
    in_ready = 1'b0;
    if (reset || trap) begin
      in_ready = 1'b0;
    end else begin
      in_ready = ((OW'(DEPTH) - count_s) >= OW'(NCOMMIT));
    end
  end

  // Push count is the contiguous valid prefix from lane 0; pack records.
  always_comb begin
    push_cnt_s = '0;
    run_s      = 1'b1;
    wr_data_s  = '0;
    for (int i = 0; i < NCOMMIT; i++) begin
      run_s = run_s & in_valid[i];
      if (in_ready && run_s) begin
        push_cnt_s = push_cnt_s + CW'(1);
      end else begin
        push_cnt_s = push_cnt_s;
      end
      wr_data_s[i*RW +: RW] = {in_pc[i*XLEN +: XLEN], in_inst[i*32 +: 32], in_wen[i],
                               in_wdest[i*5 +: 5], in_wdata[i*XLEN +: XLEN]};
    end
  end

  // Drain size and trap scan: emit oldest entries up to and including the first trap.
  always_comb begin
    avail_s    = '0;
    pop_cnt_s  = '0;
    trap_hit_s = 1'b0;
    trap_pc_s  = '0;
    if (out_en && !trap) begin
      if (count_s >= OW'(NCOMMIT)) begin
        avail_s = CW'(NCOMMIT);
      end else begin
        avail_s = CW'(count_s);
      end
    end else begin
      avail_s = '0;
    end
    for (int i = 0; i < NCOMMIT; i++) begin
      if ((CW'(i) < avail_s) && !trap_hit_s) begin
        pop_cnt_s = CW'(i + 1);
        if (is_trap(rd_data_s[i*RW + INST_LSB +: 32], TRAP_OPCODE)) begin
          trap_hit_s = 1'b1;
          trap_pc_s  = rd_data_s[i*RW + PC_LSB +: XLEN];
        end else begin
          trap_hit_s = trap_hit_s;
        end
      end else begin
        pop_cnt_s = pop_cnt_s;
      end
    end
  end

  // Commit lane registers: drained lanes carry data, unused lanes are zeroed;
  // without a drain only valid drops and the payload holds.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmt_valid <= '0;
      cmt_pc    <= '0;
      cmt_inst  <= '0;
      cmt_wen   <= '0;
      cmt_wdest <= '0;
      cmt_wdata <= '0;
    end else if (out_en && !trap) begin
      for (int i = 0; i < NCOMMIT; i++) begin
        if (CW'(i) < pop_cnt_s) begin
          cmt_valid[i]                           <= 1'b1;
          cmt_pc[i*XLEN +: XLEN]                 <= rd_data_s[i*RW + PC_LSB +: XLEN];
          cmt_inst[i*32 +: 32]                   <= rd_data_s[i*RW + INST_LSB +: 32];
          cmt_wen[i]                             <= rd_data_s[i*RW + WEN_BIT];
          cmt_wdest[i*WDEST_OUT_W +: WDEST_OUT_W] <= {{(WDEST_OUT_W-5){1'b0}},
                                                     rd_data_s[i*RW + WDEST_LSB +: 5]};
          cmt_wdata[i*XLEN +: XLEN]              <= rd_data_s[i*RW +: XLEN];
        end else begin
          cmt_valid[i]                           <= 1'b0;
          cmt_pc[i*XLEN +: XLEN]                 <= '0;
          cmt_inst[i*32 +: 32]                   <= 32'h0;
          cmt_wen[i]                             <= 1'b0;
          cmt_wdest[i*WDEST_OUT_W +: WDEST_OUT_W] <= '0;
          cmt_wdata[i*XLEN +: XLEN]              <= '0;
        end
      end
    end else begin
      cmt_valid <= '0;
    end
  end

  // Trap latch and counters; everything freezes once trap is set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      trap      <= 1'b0;
      trap_code <= 8'h00;
      trap_pc   <= '0;
      cycle_cnt <= 64'h0;
      instr_cnt <= 64'h0;
    end else if (!trap) begin
      cycle_cnt <= cycle_cnt + 64'd1;
      instr_cnt <= instr_cnt + 64'(pop_cnt_s);
      if (trap_hit_s) begin
        trap      <= 1'b1;
        trap_code <= a0_value[7:0];
        trap_pc   <= trap_pc_s;
      end
    end
  end

  assign occupancy = count_s;

endmodule

// File: tb/tb_difftest_commit_queue.sv
`timescale 1ns/1ps
// Directed bench for difftest_commit_queue with a scoreboard: expected commit
// groups are queued when stimulus is issued and a negedge monitor pops and
// compares them whenever cmt_valid is non-zero.
module tb_difftest_commit_queue;

  localparam int NC    = 2;
  localparam int DEPTH = 8;
  localparam int XLEN  = 64;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic [NC-1:0]        in_valid = '0;
  logic [NC*XLEN-1:0]   in_pc = '0;
  logic [NC*32-1:0]     in_inst = '0;
  logic [NC-1:0]        in_wen = '0;
  logic [NC*5-1:0]      in_wdest = '0;
  logic [NC*XLEN-1:0]   in_wdata = '0;
  logic                 in_ready;
  logic                 out_en = 1'b1;
  logic [XLEN-1:0]      a0_value = '0;
  logic [NC-1:0]        cmt_valid;
  logic [NC*XLEN-1:0]   cmt_pc;
  logic [NC*32-1:0]     cmt_inst;
  logic [NC-1:0]        cmt_wen;
  logic [NC*8-1:0]      cmt_wdest;
  logic [NC*XLEN-1:0]   cmt_wdata;
  logic                 trap;
  logic [7:0]           trap_code;
  logic [XLEN-1:0]      trap_pc;
  logic [63:0]          cycle_cnt;
  logic [63:0]          instr_cnt;
  logic [3:0]           occupancy;

  always #5 clock = ~clock;

  difftest_commit_queue #(.NCOMMIT(NC), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_wen(in_wen),
    .in_wdest(in_wdest), .in_wdata(in_wdata), .in_ready(in_ready),
    .out_en(out_en), .a0_value(a0_value),
    .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_inst(cmt_inst), .cmt_wen(cmt_wen),
    .cmt_wdest(cmt_wdest), .cmt_wdata(cmt_wdata),
    .trap(trap), .trap_code(trap_code), .trap_pc(trap_pc),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .occupancy(occupancy)
  );

  typedef struct packed {
    logic [NC-1:0]      valid;
    logic [NC*XLEN-1:0] pc;
    logic [NC*32-1:0]   inst;
    logic [NC-1:0]      wen;
    logic [NC*8-1:0]    wdest;
    logic [NC*XLEN-1:0] wdata;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  logic [63:0] tb_cyc;
  logic [63:0] trap_cyc;

  // Reference cycle count: edges seen since reset released.
  always @(posedge clock or posedge reset) begin
    if (reset) tb_cyc <= 64'd0;
    else       tb_cyc <= tb_cyc + 64'd1;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_lane(input int l, input logic [63:0] pc, input logic [31:0] inst,
                          input logic wen, input logic [4:0] wd, input logic [63:0] wdata);
    in_pc[l*XLEN +: XLEN]  = pc;
    in_inst[l*32 +: 32]    = inst;
    in_wen[l]              = wen;
    in_wdest[l*5 +: 5]     = wd;
    in_wdata[l*XLEN +: XLEN] = wdata;
  endtask

  // Expected commit group built from the lanes currently being driven.
  task automatic expect_out(input logic [NC-1:0] v);
    exp_t x;
    x = '0;
    x.valid = v;
    for (int l = 0; l < NC; l++) begin
      if (v[l]) begin
        x.pc[l*XLEN +: XLEN]    = in_pc[l*XLEN +: XLEN];
        x.inst[l*32 +: 32]      = in_inst[l*32 +: 32];
        x.wen[l]                = in_wen[l];
        x.wdest[l*8 +: 8]       = {3'b000, in_wdest[l*5 +: 5]};
        x.wdata[l*XLEN +: XLEN] = in_wdata[l*XLEN +: XLEN];
      end
    end
    exp_q.push_back(x);
  endtask

  // Monitor: every presented commit group must match the oldest expectation.
  always @(negedge clock) begin
    if (!reset && cmt_valid != '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit: cmt_valid=%b pc=0x%0h with nothing expected", cmt_valid, cmt_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("cmt_valid", cmt_valid, mon_e.valid);
        check("cmt_pc",    cmt_pc,    mon_e.pc);
        check("cmt_inst",  cmt_inst,  mon_e.inst);
        check("cmt_wen",   cmt_wen,   mon_e.wen);
        check("cmt_wdest", cmt_wdest, mon_e.wdest);
        check("cmt_wdata", cmt_wdata, mon_e.wdata);
      end
    end
  end

  initial begin
    // Reset state, asserted between edges.
    #1 reset = 1'b1;
    #1;
    check("rst_in_ready",  in_ready,  0);
    check("rst_cmt_valid", cmt_valid, 0);
    check("rst_cycle_cnt", cycle_cnt, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_trap",      trap,      0);
    tick(); tick();
    reset = 1'b0;

    // Idle 10 cycles with out_en high.
    repeat (10) tick();
    check("idle_cycle_cnt", cycle_cnt, 10);
    check("idle_instr_cnt", instr_cnt, 0);
    check("idle_cmt_valid", cmt_valid, 0);
    check("idle_in_ready",  in_ready,  1);

    // Single group, drained on the following edge.
    set_lane(0, 64'h8000_0000, 32'h0050_0293, 1'b1, 5'd5, 64'd5);
    set_lane(1, 64'h8000_0004, 32'h00a0_0313, 1'b1, 5'd6, 64'd10);
    in_valid = 2'b11;
    expect_out(2'b11);
    tick();
    in_valid = 2'b00;
    check("one_occ_after_push", occupancy, 2);
    tick();
    check("one_occupancy", occupancy, 0);
    check("one_instr_cnt", instr_cnt, 2);
    tick();

    // Fill to DEPTH with out_en low, then drain across the wrap point.
    out_en = 1'b0;
    for (int g = 0; g < 4; g++) begin
      set_lane(0, 64'h1000 + 64'(g*8), {12'(g*2), 5'd0, 3'b000, 5'd7, 7'h13}, 1'b1, 5'd7, 64'(g*2));
      set_lane(1, 64'h1004 + 64'(g*8), {12'(g*2+1), 5'd0, 3'b000, 5'd8, 7'h13}, 1'b1, 5'd8, 64'(g*2+1));
      check("fill_in_ready", in_ready, 1);
      in_valid = 2'b11;
      expect_out(2'b11);
      tick();
    end
    in_valid = 2'b00;
    check("full_occupancy", occupancy, 8);
    check("full_in_ready",  in_ready,  0);
    out_en = 1'b1;
    tick();
    check("drain1_in_ready",  in_ready,  1);
    check("drain1_occupancy", occupancy, 6);
    repeat (3) tick();
    check("drained_occupancy", occupancy, 0);
    check("drained_instr_cnt", instr_cnt, 10);

    // Non-contiguous valid: nothing is pushed.
    set_lane(0, 64'h1500, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
    set_lane(1, 64'h1504, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
    in_valid = 2'b10;
    tick();
    in_valid = 2'b00;
    check("gap_occupancy", occupancy, 0);
    tick();
    check("gap_instr_cnt", instr_cnt, 10);

    // Trap in lane 1: both lanes emitted, trap latched, stream frozen.
    a0_value = 64'h0;
    set_lane(0, 64'h2000, 32'h0010_0093, 1'b1, 5'd1, 64'd1);
    set_lane(1, 64'h2004, 32'h0000_006b, 1'b0, 5'd0, 64'd0);
    in_valid = 2'b11;
    expect_out(2'b11);
    tick();
    in_valid = 2'b00;
    tick();
    trap_cyc = tb_cyc;
    check("t1_trap",      trap,      1);
    check("t1_trap_code", trap_code, 0);
    check("t1_trap_pc",   trap_pc,   64'h2004);
    check("t1_instr_cnt", instr_cnt, 12);
    check("t1_cycle_cnt", cycle_cnt, trap_cyc);
    set_lane(0, 64'h3000, 32'h0010_0093, 1'b1, 5'd1, 64'd1);
    set_lane(1, 64'h3004, 32'h0010_0093, 1'b1, 5'd1, 64'd1);
    in_valid = 2'b11;
    check("t1_in_ready", in_ready, 0);
    tick(); tick();
    in_valid = 2'b00;
    check("t1_occupancy_after", occupancy, 0);
    check("t1_cycle_frozen",    cycle_cnt, trap_cyc);
    check("t1_instr_frozen",    instr_cnt, 12);

    // Reset, then trap in lane 0: lane 1 masked and left queued.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    a0_value = 64'hFFFF_0000_0000_012A;
    set_lane(0, 64'h4000, 32'h0000_006b, 1'b0, 5'd0, 64'd0);
    set_lane(1, 64'h4004, 32'h0020_0113, 1'b1, 5'd2, 64'd2);
    in_valid = 2'b11;
    expect_out(2'b01);
    tick();
    in_valid = 2'b00;
    tick();
    check("t0_trap",      trap,      1);
    check("t0_trap_code", trap_code, 8'h2A);
    check("t0_trap_pc",   trap_pc,   64'h4000);
    check("t0_instr_cnt", instr_cnt, 1);
    check("t0_occupancy", occupancy, 1);
    tick();

    // Asynchronous reset mid-cycle clears everything at once.
    #3 reset = 1'b1;
    #1;
    check("arst_cmt_valid", cmt_valid, 0);
    check("arst_cmt_pc",    cmt_pc,    0);
    check("arst_cmt_inst",  cmt_inst,  0);
    check("arst_trap",      trap,      0);
    check("arst_trap_code", trap_code, 0);
    check("arst_trap_pc",   trap_pc,   0);
    check("arst_cycle_cnt", cycle_cnt, 0);
    check("arst_instr_cnt", instr_cnt, 0);
    check("arst_occupancy", occupancy, 0);
    check("arst_in_ready",  in_ready,  0);
    tick(); tick();
    reset = 1'b0;
    tick();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/difftest_commit_queue.md
Name: difftest_commit_queue

Overview:
- Parametrised multi-lane commit buffer and trap monitor between the core's retire stage and the difftest commit/trap ports.
- Accepts up to NCOMMIT retired-instruction records per cycle and buffers them in program order in a DEPTH-entry ring.
- Drains up to NCOMMIT records per cycle to registered difftest outputs, and keeps cycle and instruction counters.
- Detects the trap instruction (opcode 7'h6b), freezes the stream and latches trap code and trap PC.

Parameters:
- NCOMMIT, 2, number of retire and commit lanes (1..4).
- DEPTH, 8, ring entries; power of two, at least 2*NCOMMIT.
- XLEN, 64, data and PC width.
- TRAP_OPCODE, 7'h6b, inst[6:0] value that marks a trap.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  NCOMMIT  per-lane retire valid; lane 0 is oldest.
- in_pc  in  NCOMMIT*XLEN  per-lane PC.
- in_inst  in  NCOMMIT*32  per-lane instruction.
- in_wen  in  NCOMMIT  per-lane GPR write enable.
- in_wdest  in  NCOMMIT*5  per-lane destination index.
- in_wdata  in  NCOMMIT*XLEN  per-lane write data.
- in_ready  out  1  queue can take a full group of NCOMMIT records this cycle.
- out_en  in  1  difftest side allows a drain this cycle.
- a0_value  in  XLEN  current architectural x10, used as the trap code source.
- cmt_valid  out  NCOMMIT  registered per-lane commit valid.
- cmt_pc  out  NCOMMIT*XLEN  registered per-lane PC.
- cmt_inst  out  NCOMMIT*32  registered per-lane instruction.
- cmt_wen  out  NCOMMIT  registered per-lane write enable.
- cmt_wdest  out  NCOMMIT*8  registered destination, zero-extended from 5 bits.
- cmt_wdata  out  NCOMMIT*XLEN  registered write data.
- trap  out  1  sticky trap flag.
- trap_code  out  8  a0_value[7:0] captured when the trap commits.
- trap_pc  out  XLEN  PC of the trap instruction.
- cycle_cnt  out  64  cycles since reset, stops at trap.
- instr_cnt  out  64  records emitted, stops at trap.
- occupancy  out  clog2(DEPTH)+1  current entry count.

Behaviour:
- Reset (asynchronous, any time, including mid-drain):
  - Every output register, both counters, head/tail pointers and count go to 0.
  - Ring contents are don't-care.
  - in_ready deasserts immediately while reset is high.
- in_ready:
  - Combinational: in_ready = ~trap & ((DEPTH - count) >= NCOMMIT).
  - It uses the pre-drain count, so there is no same-cycle credit from a simultaneous pop.
- Push:
  - When in_ready is high, lane i is written iff in_valid[0..i] are all 1 (contiguous prefix only).
  - A valid lane above a zero lane is dropped; this is a protocol error, flagged by an SVA assertion.
  - When in_ready is low, all lanes are ignored; the producer must hold its group.
  - tail advances by the pushed count, modulo DEPTH.
- Drain (when out_en and ~trap):
  - n = min(count, NCOMMIT) oldest entries are read in order onto lanes 0..n-1.
  - cmt_valid gets n low bits set; the remaining lanes get cmt_valid = 0 and all payload fields 0.
  - When out_en is 0 or trap is set, cmt_valid is 0 on the next cycle and the other cmt_* outputs hold their previous values.
- Trap:
  - If drained entry k has inst[6:0] == TRAP_OPCODE, lanes 0..k are emitted and lanes above k are masked to invalid and not popped.
  - On the same edge: trap=1, trap_code=a0_value[7:0], trap_pc=entry k pc.
  - trap stays set until reset; there are no further pushes or drains.
- Counters:
  - cycle_cnt += 1 on every edge while trap=0, including the edge on which trap sets.
  - instr_cnt += number of lanes emitted on that edge.
  - Both wrap at 2^64 with no saturation.
- Latency: a record accepted on edge k appears on cmt_* after edge k+1 at the earliest; it can be drained on the edge after it is written.
- Simultaneous push and drain:
  - count_next = count + pushed - popped.
  - Full and empty are never reached illegally, because the in_ready rule guarantees no overflow.
- Wrap-around: pointers are clog2(DEPTH) bits and a multi-entry read or write crossing index DEPTH-1 wraps to 0 seamlessly.
- Empty queue with out_en=1: cmt_valid=0 and counters other than cycle_cnt are unchanged.

Decomposition:
- Shared package difftest_pkg holds:
  - TRAP_OPCODE;
  - the commit record typedef {pc, inst, wen, wdest, wdata};
  - the constants REC_W and WDEST_OUT_W=8.
- Sub-module commit_ring_mport holds:
  - the DEPTH-entry storage with NCOMMIT write and NCOMMIT read ports;
  - pointers and count.
- The top level holds the push-prefix logic, trap scan, output registers and counters.

Test Plan:
- Reset, then idle for 10 cycles with out_en=1 -> cycle_cnt=10, instr_cnt=0, cmt_valid=0, in_ready=1.
- NCOMMIT=2: push {pc 0x80000000, 0x80000004} with out_en=1 -> cmt_valid=2'b11 two edges after push, instr_cnt=2, occupancy returns to 0.
- out_en=0 while pushing 4 groups of 2 (DEPTH=8) -> in_ready drops after the 4th group, occupancy=8; set out_en=1 -> 4 drains in PC order crossing the wrap point, in_ready reasserts after the first drain.
- in_valid=2'b10 -> nothing pushed, occupancy stays 0, assertion fires.
- Group {addi, trap 0x0000006b} with a0_value=0x0 -> lane0 and lane1 emitted, trap=1, trap_code=0, trap_pc=pc of lane1, cycle_cnt frozen; a following group is rejected (in_ready=0).
- Group {trap, addi} -> only lane0 valid, instr_cnt += 1, the addi is never emitted; assert reset mid-stream -> all outputs 0 asynchronously.
